// File: rtl/lcd_window_ctrl.sv
// LCD window controller: frame buffer load, movable/mirrorable window,
// raster streaming of the window to the panel driver.
module lcd_window_ctrl #(
  parameter int DW      = 8,
  parameter int IMG_W   = 6,
  parameter int IMG_H   = 6,
  parameter int WIN_W   = 3,
  parameter int WIN_H   = 3,
  parameter int ORG_ROW = 2,
  parameter int ORG_COL = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int N  = IMG_W * IMG_H;
  localparam int M  = WIN_W * WIN_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] C_REFRESH = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_RIGHT   = 3'd2;
  localparam logic [2:0] C_LEFT    = 3'd3;
  localparam logic [2:0] C_UP      = 3'd4;
  localparam logic [2:0] C_DOWN    = 3'd5;
  localparam logic [2:0] C_MIRROR  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_OUT,
    S_EXEC
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cmd_q, cmd_d;
  logic          busy_q, busy_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] wc_q, wc_d;
  logic [AW-1:0] orow_q, orow_d;
  logic [AW-1:0] ocol_q, ocol_d;
  logic          mir_q, mir_d;

  logic [DW-1:0] mem [N];
  logic          mem_we;
  logic [AW-1:0] row_a;
  logic [AW-1:0] col_a;
  logic [AW-1:0] rd_addr;

  // Mirror flips the column inside the window, not inside the image.
  always_comb begin
    row_a   = orow_q + wr_q;
    col_a   = mir_q ? (ocol_q + AW'(WIN_W - 1) - wc_q)
                    : (ocol_q + wc_q);
    rd_addr = row_a * AW'(IMG_W) + col_a;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    ov_d    = 1'b0;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    mir_d   = mir_q;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd;
          busy_d = 1'b1;
          cnt_d  = '0;
          wr_d   = '0;
          wc_d   = '0;
          if (cmd == C_LOAD)
            state_d = S_LOAD;
          else if (cmd == C_REFRESH)
            state_d = S_OUT;
          else
            state_d = S_EXEC;
        end
      end
      S_LOAD: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_OUT: begin
        if (cnt_q < CW'(M)) begin
          dout_d = mem[rd_addr];
          ov_d   = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (wc_q == AW'(WIN_W - 1)) begin
            wc_d = '0;
            wr_d = wr_q + 1'b1;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        case (cmd_q)
          C_RIGHT:
            if (ocol_q < AW'(IMG_W - WIN_W))
              ocol_d = ocol_q + 1'b1;
          C_LEFT:
            if (ocol_q > '0)
              ocol_d = ocol_q - 1'b1;
          C_UP:
            if (orow_q > '0)
              orow_d = orow_q - 1'b1;
          C_DOWN:
            if (orow_q < AW'(IMG_H - WIN_H))
              orow_d = orow_q + 1'b1;
          C_MIRROR:
            mir_d = ~mir_q;
          default: begin
            orow_d = AW'(ORG_ROW);
            ocol_d = AW'(ORG_COL);
            mir_d  = 1'b0;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
      orow_q  <= AW'(ORG_ROW);
      ocol_q  <= AW'(ORG_COL);
      mir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      mir_q   <= mir_d;
    end
  end

  // Frame buffer survives reset so a partial load keeps written pixels.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[cnt_q[AW-1:0]] <= datain;
  end

  assign dataout      = dout_q;
  assign output_valid = ov_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_window_ctrl.sv
// Bench for lcd_window_ctrl: two parameter sets, scoreboard against
// a frame/window reference model.
module tb_lcd_window_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] din [2];
  logic [2:0] cm [2];
  logic       cv [2];
  logic [7:0] dout_w [2];
  logic       ov_w [2];
  logic       busy_w [2];

  int compared;
  int mismatched;

  int W [2], H [2], WW [2], WH [2], ORR [2], ORC [2];
  int orow [2], ocol [2], mir [2];
  int img0 [64];
  int img1 [64];
  int expq0 [$];
  int expq1 [$];

  lcd_window_ctrl dut0 (
    .clk(clk), .reset(reset), .datain(din[0]), .cmd(cm[0]),
    .cmd_valid(cv[0]), .dataout(dout_w[0]),
    .output_valid(ov_w[0]), .busy(busy_w[0])
  );

  lcd_window_ctrl #(
    .DW(8), .IMG_W(8), .IMG_H(4), .WIN_W(4), .WIN_H(2),
    .ORG_ROW(1), .ORG_COL(2)
  ) dut1 (
    .clk(clk), .reset(reset), .datain(din[1]), .cmd(cm[1]),
    .cmd_valid(cv[1]), .dataout(dout_w[1]),
    .output_valid(ov_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ov_w[0] === 1'b1) begin
      if (expq0.size() == 0)
        chk("dut0_unexpected_pixel", 1, 0);
      else
        chk("dut0_pixel", dout_w[0], expq0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov_w[1] === 1'b1) begin
      if (expq1.size() == 0)
        chk("dut1_unexpected_pixel", 1, 0);
      else
        chk("dut1_pixel", dout_w[1], expq1.pop_front());
    end
  end

  function automatic int pix(input int i, input int a);
    return (i == 0) ? img0[a] : img1[a];
  endfunction

  task automatic push_window(input int i);
    int cc, v;
    for (int r = 0; r < WH[i]; r++)
      for (int c = 0; c < WW[i]; c++) begin
        cc = mir[i] ? (WW[i] - 1 - c) : c;
        v = pix(i, (orow[i] + r) * W[i] + ocol[i] + cc);
        if (i == 0) expq0.push_back(v);
        else expq1.push_back(v);
      end
  endtask

  task automatic model_cmd(input int i, input int c);
    case (c)
      2: if (ocol[i] < W[i] - WW[i]) ocol[i]++;
      3: if (ocol[i] > 0) ocol[i]--;
      4: if (orow[i] > 0) orow[i]--;
      5: if (orow[i] < H[i] - WH[i]) orow[i]++;
      6: mir[i] = 1 - mir[i];
      7: begin orow[i] = ORR[i]; ocol[i] = ORC[i]; mir[i] = 0; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      orow[i] = ORR[i];
      ocol[i] = ORC[i];
      mir[i] = 0;
    end
  endtask

  // Called at a negedge with the target idle; returns at a negedge.
  task automatic send(input int i, input int c, input bit seq,
                      input int ignore_at, input int abort_at);
    int n, exp_n, v;
    chk("busy_before_cmd", busy_w[i], 0);
    cm[i] = 3'(c);
    cv[i] = 1'b1;
    if (c == 1) exp_n = W[i] * H[i];
    else if (c == 0) exp_n = WW[i] * WH[i] + 1;
    else exp_n = 1;
    if (c == 0) push_window(i);
    else if (c >= 2) model_cmd(i, c);
    @(negedge clk);
    cv[i] = 1'b0;
    n = 0;
    while (busy_w[i] === 1'b1 && n < 300) begin
      if (c == 1 && n < W[i] * H[i]) begin
        v = seq ? n : int'($urandom_range(0, 255));
        din[i] = 8'(v);
        if (i == 0) img0[n] = v;
        else img1[n] = v;
      end
      if (n == ignore_at) begin
        cm[i] = 3'd2;
        cv[i] = 1'b1;
      end else begin
        cv[i] = 1'b0;
      end
      if (n == abort_at) begin
        #1;
        reset = 1'b1;
        #1;
        chk("abort_valid", ov_w[i], 0);
        chk("abort_busy", busy_w[i], 0);
        chk("abort_dataout", dout_w[i], 0);
        if (i == 0) expq0.delete();
        else expq1.delete();
        model_reset();
        @(negedge clk);
        chk("held_reset_valid", ov_w[i], 0);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      n++;
      @(negedge clk);
    end
    cv[i] = 1'b0;
    chk("busy_cycles", n, exp_n);
    if (c == 0) begin
      chk("valid_with_busy_fall", ov_w[i], 0);
      chk("stream_drained", (i == 0) ? expq0.size() : expq1.size(), 0);
    end
  endtask

  initial begin
    int c;
    compared = 0;
    mismatched = 0;
    W[0] = 6; H[0] = 6; WW[0] = 3; WH[0] = 3; ORR[0] = 2; ORC[0] = 2;
    W[1] = 8; H[1] = 4; WW[1] = 4; WH[1] = 2; ORR[1] = 1; ORC[1] = 2;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      din[i] = '0;
      cm[i] = '0;
      cv[i] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_dataout", dout_w[i], 0);
      chk("reset_valid", ov_w[i], 0);
      chk("reset_busy", busy_w[i], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    send(0, 1, 1, -1, -1);
    send(0, 0, 0, -1, -1);
    send(0, 2, 0, -1, -1);
    send(0, 2, 0, -1, -1);
    send(0, 0, 0, -1, -1);
    send(0, 7, 0, -1, -1);
    send(0, 4, 0, -1, -1);
    send(0, 4, 0, -1, -1);
    send(0, 4, 0, -1, -1);
    send(0, 0, 0, -1, -1);
    send(0, 7, 0, -1, -1);
    send(0, 6, 0, -1, -1);
    send(0, 0, 0, -1, -1);
    send(0, 7, 0, -1, -1);
    send(0, 0, 0, -1, -1);
    send(0, 0, 0, 5, -1);
    send(0, 0, 0, -1, -1);
    send(0, 0, 0, -1, 4);
    send(0, 0, 0, -1, -1);

    send(1, 1, 1, -1, -1);
    send(1, 5, 0, -1, -1);
    send(1, 5, 0, -1, -1);
    send(1, 0, 0, -1, -1);
    send(1, 3, 0, -1, -1);
    send(1, 3, 0, -1, -1);
    send(1, 3, 0, -1, -1);
    send(1, 6, 0, -1, -1);
    send(1, 0, 0, -1, -1);

    for (int k = 0; k < 80; k++) begin
      c = int'($urandom_range(0, 7));
      if (c == 1 && $urandom_range(0, 2) != 0)
        c = 0;
      send(k % 2, c, 0, -1, -1);
    end

    chk("final_queue0", expq0.size(), 0);
    chk("final_queue1", expq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_window_ctrl.md
Name: lcd_window_ctrl

Overview:
- Parametrised LCD window controller.
- Loads an IMG_W x IMG_H frame of DW-bit pixels into an internal buffer.
- Keeps a movable WIN_W x WIN_H viewing window with a horizontal-mirror mode.
- Streams the window out in raster order on request. Sits between the host command port and the LCD panel driver.

Parameters:
- DW, 8, pixel width in bits
- IMG_W, 6, image width in pixels
- IMG_H, 6, image height in pixels
- WIN_W, 3, window width in pixels (1 <= WIN_W <= IMG_W)
- WIN_H, 3, window height in pixels (1 <= WIN_H <= IMG_H)
- ORG_ROW, 2, window origin row after reset/HOME (must be <= IMG_H-WIN_H)
- ORG_COL, 2, window origin column after reset/HOME (must be <= IMG_W-WIN_W)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- datain  input  DW  pixel data during LOAD
- cmd  input  3  command code
- cmd_valid  input  1  command strobe
- dataout  output  DW  window pixel during REFRESH
- output_valid  output  1  dataout is valid this cycle
- busy  output  1  command in progress; new commands ignored

Behaviour:
- Reset values: dataout=0, output_valid=0, busy=0, origin=(ORG_ROW,ORG_COL), mirror=0, FSM=IDLE. Buffer contents are not reset and are undefined until the first LOAD.
- Command codes:
  - 0 REFRESH
  - 1 LOAD
  - 2 RIGHT
  - 3 LEFT
  - 4 UP
  - 5 DOWN
  - 6 MIRROR (toggle mirror flag)
  - 7 HOME (origin=(ORG_ROW,ORG_COL), mirror=0)
- FSM states: IDLE, LOAD, OUT, EXEC.
- Acceptance: at an edge where FSM=IDLE and cmd_valid=1 (call it T0), cmd is latched and busy goes to 1 at T0. cmd_valid while busy=1 is ignored, with no queuing.
- LOAD (IDLE->LOAD):
  - datain is sampled at edges T1..TN, N=IMG_W*IMG_H, in raster order: index = row*IMG_W + col.
  - busy is cleared at TN; FSM returns to IDLE at TN.
  - Origin and mirror are unchanged.
- REFRESH (IDLE->OUT):
  - At edges T1..TM, M=WIN_W*WIN_H, dataout is registered with window pixel k, and output_valid=1.
  - At T(M+1): output_valid=0, busy=0, FSM=IDLE. dataout holds its last value.
  - Window pixel order is row-major. Pixel (r,c), r in 0..WIN_H-1, maps to buffer[(orow+r)*IMG_W + ocol+c'].
    - Mirror=0: c'=c.
    - Mirror=1: c'=WIN_W-1-c, so each row is emitted right-to-left.
  - The address is computed with widths sufficient for IMG_W*IMG_H-1 (clog2-based), with no truncation.
- RIGHT/LEFT/UP/DOWN/MIRROR/HOME (IDLE->EXEC):
  - The state update and busy=0 both occur at T1; FSM returns to IDLE at T1.
  - Clamping:
    - RIGHT: ocol+1 only if ocol < IMG_W-WIN_W.
    - LEFT: ocol-1 only if ocol > 0.
    - UP: orow-1 only if orow > 0.
    - DOWN: orow+1 only if orow < IMG_H-WIN_H.
  - A shift at the boundary is a no-op but still takes one busy cycle.
- Earliest next command is the edge after busy falls, sampled with busy=0. Back-to-back commands are allowed.
- Reset asserted mid-operation: everything immediately returns to the reset values. A partial LOAD leaves already-written pixels in the buffer. An aborted REFRESH produces no further output_valid.
- Degenerate sizes: if WIN_W=IMG_W, RIGHT/LEFT are always no-ops; the same holds for rows.

Test Plan:
- Defaults. LOAD pixels 0..35, then REFRESH -> output_valid for exactly 9 consecutive cycles with dataout 14,15,16,20,21,22,26,27,28; busy falls with output_valid.
- RIGHT, RIGHT (second clamps at col 3), then REFRESH -> 15,16,17,21,22,23,27,28,29; each shift holds busy high for exactly 1 cycle.
- UP x3 from origin (2,2) (third is a no-op at row 0), then REFRESH -> 2,3,4,8,9,10,14,15,16.
- MIRROR, then REFRESH at origin (2,2) -> 16,15,14,22,21,20,28,27,26. HOME, then REFRESH -> 14,15,16,20,...,28.
- Pulse cmd_valid with cmd=2 during the middle of a REFRESH -> it is ignored: origin is unchanged and the 9-pixel stream is uninterrupted.
- Assert reset at the 4th REFRESH output -> output_valid=0 and busy=0 immediately; a following REFRESH without reload outputs from origin (2,2) with the previously loaded data.
- Parameter set IMG 8x4, WIN 4x2, ORG (1,2). Load 0..31, DOWN, DOWN (clamps at row 2), then REFRESH -> 18,19,20,21,26,27,28,29.
